// File: rtl/mat_mul_loader_if.sv
// Streaming handshake bundle for the matrix-vector loader:
// word-serial input frames in, word-serial result words out.
interface mat_mul_loader_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic                out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mat_mul_loader.sv
// Loads an N x N matrix, vector and bias from a word stream into registers for a
// combinational matrix-vector core, captures its result and drains it word by word.
module mat_mul_loader #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mat_mul_loader_if.slave     bus,
    output logic signed [W-1:0] mat1_o [N][N],
    output logic signed [W-1:0] vec_o  [N],
    output logic signed [W-1:0] bias_o [N],
    input  logic signed [W-1:0] res_i  [N],
    output logic                err
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
    localparam logic [CW-1:0] IDX_ONE  = CW'(1);

    typedef enum logic [2:0] {
        LOAD_MAT  = 3'd0,
        LOAD_VEC  = 3'd1,
        LOAD_BIAS = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       row_r;
    logic [CW-1:0]       col_r;
    logic [CW-1:0]       k_r;
    logic signed [W-1:0] res_buf_r [N];
    logic                err_r;

    logic                accept_s;
    logic                stage_done_s;
    logic                frame_err_s;
    logic                in_ready_s;
    logic                out_valid_s;
    logic                out_last_s;
    logic signed [W-1:0] out_data_s;

    assign accept_s     = bus.in_valid && in_ready_s;
    // Row only advances in LOAD_MAT, so it is zero in the vector and bias stages.
    assign stage_done_s = (col_r == IDX_LAST) && ((state_r != LOAD_MAT) || (row_r == IDX_LAST));

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_last  = out_last_s;
    assign err           = err_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD_MAT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode, including framing-error detection on the in_last marker.
    always_comb begin
        state_s     = state_r;
        frame_err_s = 1'b0;
        case (state_r)
            LOAD_MAT, LOAD_VEC: begin
                if (accept_s && bus.in_last) begin
                    frame_err_s = 1'b1;
                    state_s     = LOAD_MAT;
                end else if (accept_s && stage_done_s) begin
                    state_s = (state_r == LOAD_MAT) ? LOAD_VEC : LOAD_BIAS;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD_BIAS: begin
                // in_last must coincide exactly with the final bias word.
                if (accept_s && (bus.in_last != stage_done_s)) begin
                    frame_err_s = 1'b1;
                    state_s     = LOAD_MAT;
                end else if (accept_s && stage_done_s) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = LOAD_BIAS;
                end
            end
            CAPTURE: begin
                state_s = DRAIN;
            end
            DRAIN: begin
                if (bus.out_ready && (k_r == IDX_LAST)) begin
                    state_s = LOAD_MAT;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = LOAD_MAT;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_data_s  = '0;
        case (state_r)
            LOAD_MAT, LOAD_VEC, LOAD_BIAS: begin
                in_ready_s = 1'b1;
            end
            DRAIN: begin
                out_valid_s = 1'b1;
                out_data_s  = res_buf_r[k_r];
                out_last_s  = (k_r == IDX_LAST);
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Operand loading, word counters and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r <= '0;
            col_r <= '0;
            err_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                vec_o[i]  <= '0;
                bias_o[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    mat1_o[i][j] <= '0;
                end
            end
        end else begin
            err_r <= err_r | frame_err_s;
            if (frame_err_s) begin
                // Offending word is dropped; earlier words of the frame stay put.
                row_r <= '0;
                col_r <= '0;
            end else if (accept_s) begin
                case (state_r)
                    LOAD_MAT:  mat1_o[row_r][col_r] <= bus.in_data;
                    LOAD_VEC:  vec_o[col_r]         <= bus.in_data;
                    LOAD_BIAS: bias_o[col_r]        <= bus.in_data;
                    default:   ;
                endcase
                if (col_r == IDX_LAST) begin
                    col_r <= '0;
                    if (state_r == LOAD_MAT) begin
                        row_r <= (row_r == IDX_LAST) ? '0 : row_r + IDX_ONE;
                    end
                end else begin
                    col_r <= col_r + IDX_ONE;
                end
            end
        end
    end

    // Result capture and drain index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r <= '0;
            for (int i = 0; i < N; i++) begin
                res_buf_r[i] <= '0;
            end
        end else begin
            if (state_r == CAPTURE) begin
                for (int i = 0; i < N; i++) begin
                    res_buf_r[i] <= res_i[i];
                end
            end
            if (out_valid_s && bus.out_ready) begin
                k_r <= (k_r == IDX_LAST) ? '0 : k_r + IDX_ONE;
            end
        end
    end
endmodule

// File: tb/tb_mat_mul_loader.sv
// Self-checking bench for mat_mul_loader (N=2, W=16) with a behavioural core and
// a frame-level reference model.
module tb_mat_mul_loader;
    localparam int N  = 2;
    localparam int W  = 16;
    localparam int FW = N * N + 2 * N;

    typedef logic signed [W-1:0] word_t;
    typedef word_t frame_t [FW];
    typedef word_t res_t [N];

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    word_t mat1_o [N][N];
    word_t vec_o  [N];
    word_t bias_o [N];
    word_t res_i  [N];
    logic  err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    word_t oq_data[$];
    logic  oq_last[$];
    int    oq_cyc[$];
    int    acc_cyc_q[$];
    int    lastin_q[$];
    int    ov_rise_q[$];
    logic  ov_prev = 1'b0;

    mat_mul_loader_if #(.W(W)) bus ();

    mat_mul_loader #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .mat1_o (mat1_o),
        .vec_o  (vec_o),
        .bias_o (bias_o),
        .res_i  (res_i),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural matrix-vector core fed from the loader's registers.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            longint acc;
            acc = longint'(bias_o[i]);
            for (int j = 0; j < N; j++) begin
                acc = acc + longint'(mat1_o[i][j]) * longint'(vec_o[j]);
            end
            res_i[i] = acc[W-1:0];
        end
    end

    // Mid-cycle observer of handshakes on both sides.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            acc_cyc_q.push_back(cyc);
            if (bus.in_last) lastin_q.push_back(cyc);
        end
        if (bus.out_valid && !ov_prev) ov_rise_q.push_back(cyc);
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            oq_data.push_back(bus.out_data);
            oq_last.push_back(bus.out_last);
            oq_cyc.push_back(cyc);
        end
    end

    // Reference: y = M*v + b on whole integers, then keep the low W bits.
    function automatic void ref_model(input frame_t f, output res_t r);
        for (int i = 0; i < N; i++) begin
            longint acc;
            acc = longint'(f[N * N + N + i]);
            for (int j = 0; j < N; j++) begin
                acc = acc + longint'(f[i * N + j]) * longint'(f[N * N + j]);
            end
            r[i] = acc[W-1:0];
        end
    endfunction

    task automatic drive_word(input word_t d, input logic l, input int gap);
        int n;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_accept_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // gap_mode: 0 = back-to-back words, 1 = in_valid toggling, 2 = random gaps
    task automatic send_frame(input frame_t f, input int nwords, input int last_pos, input int gap_mode);
        for (int i = 0; i < nwords; i++) begin
            int g;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            drive_word(f[i], 1'(i == last_pos), g);
        end
    endtask

    task automatic wait_outs(input int target, input bit rnd);
        int t;
        t = 0;
        while (oq_data.size() < target && t < 300) begin
            @(posedge clk); #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        if (oq_data.size() < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_timeout: got %0d words required %0d", oq_data.size(), target);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int nz;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (vec_o[i] !== 16'sd0 || bias_o[i] !== 16'sd0) nz++;
            for (int j = 0; j < N; j++) if (mat1_o[i][j] !== 16'sd0) nz++;
        end
        n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL reset_regs: nonzero=%0d required 0", nz); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b required 0", err); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b required 0", bus.out_last); end
        n_checks++; if (bus.out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d required 0", bus.out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        frame_t f;
        int b0;
        f  = '{16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd3, -16'sd4, 16'sd10, 16'sd20};
        b0 = oq_data.size();
        bus.out_ready = 1'b1;
        send_frame(f, FW, FW - 1, 0);
        wait_outs(b0 + 2, 1'b0);
        if (oq_data.size() >= b0 + 2) begin
            n_checks++; if (oq_data[b0] !== 16'sd13) begin n_fail++; $display("FAIL basic_r0: got %0d required 13", oq_data[b0]); end
            n_checks++; if (oq_data[b0+1] !== 16'sd16) begin n_fail++; $display("FAIL basic_r1: got %0d required 16", oq_data[b0+1]); end
            n_checks++; if (oq_last[b0] !== 1'b0) begin n_fail++; $display("FAIL basic_last0: got %0b required 0", oq_last[b0]); end
            n_checks++; if (oq_last[b0+1] !== 1'b1) begin n_fail++; $display("FAIL basic_last1: got %0b required 1", oq_last[b0+1]); end
        end
        n_checks++;
        if (ov_rise_q[$] - lastin_q[$] !== 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles required 2", ov_rise_q[$] - lastin_q[$]);
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %0b required 0", err); end
    endtask

    task automatic test_stall();
        frame_t f;
        int b0;
        int n;
        f  = '{16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd3, -16'sd4, 16'sd10, 16'sd20};
        b0 = oq_data.size();
        bus.out_ready = 1'b0;
        send_frame(f, FW, FW - 1, 1);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b required 1", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b required 0", bus.in_ready); end
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin @(posedge clk); #1; @(negedge clk); end
            n_checks++; if (bus.out_data !== 16'sd13) begin n_fail++; $display("FAIL stall_hold_data[%0d]: got %0d required 13", s, bus.out_data); end
            n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL stall_hold_last[%0d]: got %0b required 0", s, bus.out_last); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_outs(b0 + 2, 1'b0);
        if (oq_data.size() >= b0 + 2) begin
            n_checks++; if (oq_data[b0] !== 16'sd13) begin n_fail++; $display("FAIL stall_r0: got %0d required 13", oq_data[b0]); end
            n_checks++; if (oq_data[b0+1] !== 16'sd16) begin n_fail++; $display("FAIL stall_r1: got %0d required 16", oq_data[b0+1]); end
            n_checks++; if (oq_last[b0+1] !== 1'b1) begin n_fail++; $display("FAIL stall_last1: got %0b required 1", oq_last[b0+1]); end
        end
    endtask

    task automatic test_frame_err();
        frame_t f;
        f = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd1, 16'sd1, 16'sd0, 16'sd0};
        send_frame(f, 4, 3, 0);
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ferr_err: got %0b required 1", err); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ferr_in_ready: got %0b required 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_out_valid: got %0b required 0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_after_err();
        frame_t f;
        int b0;
        f  = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd1, 16'sd1, 16'sd0, 16'sd0};
        b0 = oq_data.size();
        send_frame(f, FW, FW - 1, 0);
        wait_outs(b0 + 2, 1'b0);
        if (oq_data.size() >= b0 + 2) begin
            n_checks++; if (oq_data[b0] !== 16'sd3) begin n_fail++; $display("FAIL aerr_r0: got %0d required 3", oq_data[b0]); end
            n_checks++; if (oq_data[b0+1] !== 16'sd7) begin n_fail++; $display("FAIL aerr_r1: got %0d required 7", oq_data[b0+1]); end
        end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL aerr_sticky: got %0b required 1", err); end
    endtask

    task automatic test_wrap();
        frame_t f;
        int b0;
        f  = '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 16'sd2, 16'sd0};
        b0 = oq_data.size();
        send_frame(f, FW, FW - 1, 0);
        wait_outs(b0 + 2, 1'b0);
        if (oq_data.size() >= b0 + 2) begin
            n_checks++; if (oq_data[b0] !== 16'sd0) begin n_fail++; $display("FAIL wrap_r0: got %0d required 0", oq_data[b0]); end
            n_checks++; if (oq_data[b0+1] !== 16'sd0) begin n_fail++; $display("FAIL wrap_r1: got %0d required 0", oq_data[b0+1]); end
            n_checks++; if (oq_last[b0+1] !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %0b required 1", oq_last[b0+1]); end
        end
    endtask

    task automatic test_mid_reset();
        frame_t f;
        int b0;
        int nz;
        f  = '{16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd2, 16'sd3, 16'sd1, 16'sd1};
        b0 = oq_data.size();
        send_frame(f, 3, -1, 0);
        rst_n = 1'b0;
        #2;
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (vec_o[i] !== 16'sd0 || bias_o[i] !== 16'sd0) nz++;
            for (int j = 0; j < N; j++) if (mat1_o[i][j] !== 16'sd0) nz++;
        end
        n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL mrst_regs: nonzero=%0d required 0", nz); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %0b required 0", err); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %0b required 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 16'sd0) begin n_fail++; $display("FAIL mrst_out_data: got %0d required 0", bus.out_data); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(f, FW, FW - 1, 0);
        wait_outs(b0 + 2, 1'b0);
        if (oq_data.size() >= b0 + 2) begin
            n_checks++; if (oq_data[b0] !== 16'sd29) begin n_fail++; $display("FAIL mrst_r0: got %0d required 29", oq_data[b0]); end
            n_checks++; if (oq_data[b0+1] !== 16'sd39) begin n_fail++; $display("FAIL mrst_r1: got %0d required 39", oq_data[b0+1]); end
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (oq_data.size() !== b0 + 2) begin n_fail++; $display("FAIL mrst_count: got %0d words required %0d", oq_data.size() - b0, 2); end
    endtask

    task automatic test_back_to_back();
        frame_t f1;
        frame_t f2;
        res_t   r1;
        res_t   r2;
        int b0;
        int a0;
        for (int i = 0; i < FW; i++) begin
            f1[i] = word_t'($urandom_range(0, 65535));
            f2[i] = word_t'($urandom_range(0, 65535));
        end
        ref_model(f1, r1);
        ref_model(f2, r2);
        b0 = oq_data.size();
        a0 = acc_cyc_q.size();
        bus.out_ready = 1'b1;
        send_frame(f1, FW, FW - 1, 0);
        send_frame(f2, FW, FW - 1, 0);
        wait_outs(b0 + 2 * N, 1'b0);
        if (oq_data.size() >= b0 + 2 * N && acc_cyc_q.size() >= a0 + FW + 1) begin
            for (int i = 0; i < N; i++) begin
                n_checks++; if (oq_data[b0+i] !== r1[i]) begin n_fail++; $display("FAIL b2b_f1_r%0d: got %0d required %0d", i, oq_data[b0+i], r1[i]); end
                n_checks++; if (oq_data[b0+N+i] !== r2[i]) begin n_fail++; $display("FAIL b2b_f2_r%0d: got %0d required %0d", i, oq_data[b0+N+i], r2[i]); end
            end
            n_checks++;
            if (acc_cyc_q[a0+FW] !== oq_cyc[b0+N-1] + 1) begin
                n_fail++; $display("FAIL b2b_restart: first word at cycle %0d required %0d", acc_cyc_q[a0+FW], oq_cyc[b0+N-1] + 1);
            end
        end
    endtask

    task automatic test_random();
        frame_t f;
        res_t   r;
        int b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < FW; i++) begin
                f[i] = (k[0]) ? word_t'($urandom_range(0, 65535)) : word_t'(int'($urandom_range(0, 200)) - 100);
            end
            ref_model(f, r);
            b0 = oq_data.size();
            send_frame(f, FW, FW - 1, 2);
            wait_outs(b0 + N, 1'b1);
            if (oq_data.size() >= b0 + N) begin
                for (int i = 0; i < N; i++) begin
                    n_checks++; if (oq_data[b0+i] !== r[i]) begin n_fail++; $display("FAIL rand%0d_r%0d: got %0d required %0d", k, i, oq_data[b0+i], r[i]); end
                    n_checks++; if (oq_last[b0+i] !== 1'(i == N - 1)) begin n_fail++; $display("FAIL rand%0d_last%0d: got %0b required %0b", k, i, oq_last[b0+i], i == N - 1); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_frame_err();
        test_after_err();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mat_mul_loader.md
MAT_MUL_LOADER -- requirements
Module: mat_mul_loader

Interface
REQ-001 SHALL have parameter N, default 16, giving the matrix dimension (N x N matrix, N-element vectors).
REQ-002 SHALL have parameter W, default 16, giving the signed data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input word valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts input word.
REQ-007 SHALL have port in_data  input  W signed  input word (matrix, then vector, then bias).
REQ-008 SHALL have port in_last  input  1  marks final word of a frame.
REQ-009 SHALL have port mat1_o  output  [N][N] x W signed  registered matrix to the matrix-vector core.
REQ-010 SHALL have port vec_o  output  [N] x W signed  registered vector to the core.
REQ-011 SHALL have port bias_o  output  [N] x W signed  registered bias to the core.
REQ-012 SHALL have port res_i  input  [N] x W signed  combinational result from the core.
REQ-013 SHALL have port out_valid  output  1  result word valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result word.
REQ-015 SHALL have port out_data  output  W signed  result word.
REQ-016 SHALL have port out_last  output  1  marks result element N-1.
REQ-017 SHALL have port err  output  1  sticky framing-error flag.

Function
REQ-018 SHALL implement FSM states LOAD_MAT, LOAD_VEC, LOAD_BIAS, CAPTURE, DRAIN.
REQ-019 A word SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL be 1 in LOAD_MAT, LOAD_VEC and LOAD_BIAS, and 0 in CAPTURE and DRAIN.
REQ-021 LOAD_MAT SHALL write accepted words to mat1_o row-major (row i, column j; j increments first), N*N words, then go to LOAD_VEC.
REQ-022 LOAD_VEC SHALL write N accepted words to vec_o[0..N-1], then go to LOAD_BIAS.
REQ-023 LOAD_BIAS SHALL write N accepted words to bias_o[0..N-1], then go to CAPTURE.
REQ-024 A frame SHALL be exactly N*N+2N words, with in_last=1 on the final bias word only.
REQ-025 If in_last=1 on any earlier word, or in_last=0 on the final bias word, the loader SHALL set err=1, discard the frame, clear the word counters and return to LOAD_MAT on the next cycle.
REQ-026 Registers already written by a discarded frame SHALL keep their values until overwritten.
REQ-027 err SHALL stay 1 until reset.
REQ-028 In CAPTURE, held for exactly one cycle, the loader SHALL register res_i[0..N-1] into an internal result buffer, then go to DRAIN.
REQ-029 res_i SHALL be treated as a W-bit truncated value; no width extension or saturation is applied.
REQ-030 mat1_o, vec_o and bias_o SHALL remain stable from CAPTURE until the next accepted word.
REQ-031 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal buffer[k], with k starting at 0.
REQ-032 In DRAIN, k SHALL advance only on out_valid && out_ready.
REQ-033 In DRAIN, out_last SHALL be 1 when k = N-1.
REQ-034 While out_ready=0 in DRAIN, out_data and out_last SHALL hold stable.
REQ-035 On the handshake of k = N-1, the loader SHALL go to LOAD_MAT, and in_ready SHALL be 1 on the next cycle.
REQ-036 Latency: with the final bias word accepted in cycle t, the state SHALL be CAPTURE in cycle t+1 and out_valid SHALL first be 1 in cycle t+2.
REQ-037 The N result words SHALL then drain at up to one word per cycle.
REQ-038 out_valid SHALL be 0 outside DRAIN.
REQ-039 No input word SHALL be accepted while CAPTURE or DRAIN is active.

Reset
REQ-040 rst_n=0 SHALL immediately force state LOAD_MAT, all counters 0, and mat1_o, vec_o, bias_o and the result buffer to 0.
REQ-041 rst_n=0 SHALL immediately force out_valid=0, out_last=0, out_data=0 and err=0.
REQ-042 Reset asserted mid-frame or mid-drain SHALL abandon that operation with no partial output.
REQ-043 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (bench: N=2, W=16, behavioural core res_i[i] = sum_j mat1_o[i][j]*vec_o[j] + bias_o[i], truncated to W bits)
REQ-044 Bench SHALL stream frame 1,0,0,1 | 3,-4 | 10,20 (last on 20), out_ready=1 -> out_data 13 then 16, out_last on 16, out_valid 2 cycles after the last input.
REQ-045 Bench SHALL stream the same frame with in_valid toggling every cycle and out_ready low for 3 cycles in DRAIN -> identical results, out_data held at 13 during the stall.
REQ-046 Bench SHALL stream frame 1,2,3,4 | 1,1 | 0,0 with in_last=1 on the 4th word -> err=1, state back to LOAD_MAT.
REQ-047 Bench SHALL follow REQ-046 with a correct frame 1,2,3,4 | 1,1 | 0,0 -> results 3, 7; err remains 1.
REQ-048 Bench SHALL stream frame 32767,32767,0,0 | 1,1 | 2,0 -> out_data 0 (wrap: 65536 truncated to 16 bits is 0), then 0.
REQ-049 Bench SHALL assert rst_n=0 after 3 of 8 words, then send a full valid frame -> all outputs 0 during reset and a correct result for the new frame only.
REQ-050 Bench SHALL send two back-to-back frames with out_ready=1 -> the 2nd frame's first word is accepted the cycle after out_last, and both result pairs are correct.
